// File: rtl/wash_actuator_executor.sv
// Washer actuator executor: queues the controller's phase pulses and runs each
// phase as a timed valve/heater/motor sequence. It also registers the sensor
// readiness flags that are returned to the controller.
module wash_actuator_executor #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FILL_TIMEOUT = 16,
  parameter int unsigned WASH_CYCLES  = 32,
  parameter int unsigned RINSE_CYCLES = 24,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned SPIN_CYCLES  = 20,
  parameter int unsigned TEMP_TARGET  = 40,
  parameter int unsigned LOAD_MAX     = 70
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wash_enable,
  input  logic       i_rinse_enable,
  input  logic       i_spin_enable,
  input  logic       i_complete,
  input  logic       i_supply_ok,
  input  logic       i_level_full,
  input  logic [7:0] i_temp_c,
  input  logic [7:0] i_load_kg,
  input  logic       i_door_closed,
  output logic       o_water_ready,
  output logic       o_temp_ready,
  output logic       o_load_ready,
  output logic       o_fill_valve,
  output logic       o_drain_valve,
  output logic       o_heater_on,
  output logic       o_motor_on,
  output logic       o_motor_fast,
  output logic       o_door_lock,
  output logic       o_busy,
  output logic       o_phase_done,
  output logic       o_fault
);

  localparam int unsigned QDEPTH  = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned QCNT_W  = 3;
  localparam int unsigned SENS_W  = 8;

  typedef enum logic [1:0] {OP_WASH, OP_RINSE, OP_SPIN, OP_DONE} op_e;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_AGITATE, S_DRAIN, S_SPIN, S_FAULT} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_timer;
  logic                r_kind_wash;
  op_e                 r_q [QDEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [QCNT_W-1:0]   r_count;
  logic r_water_ready, r_temp_ready, r_load_ready;
  logic r_fill_valve, r_drain_valve, r_heater_on, r_motor_on, r_motor_fast;
  logic r_door_lock, r_busy, r_phase_done, r_fault;

  state_e              w_state_nxt;
  logic [CNT_W-1:0]    w_timer_nxt;
  logic                w_kind_wash_nxt, w_lock_nxt, w_done_nxt;
  logic                w_pop, w_push, w_fill_to, w_overflow, w_multi_err, w_fault_set;
  logic [QCNT_W-1:0]   w_count_nxt;
  logic [2:0]          w_cmd_sum;
  logic                w_one_cmd, w_q_full;
  op_e                 w_cmd_op, w_head;

  // Decode the command inputs into a single opcode and a legality flag
  always_comb begin
    w_cmd_sum = 3'(i_wash_enable) + 3'(i_rinse_enable) + 3'(i_spin_enable) + 3'(i_complete);
    w_one_cmd = (w_cmd_sum == 3'd1);
    w_cmd_op  = OP_DONE;
    if (i_wash_enable)       w_cmd_op = OP_WASH;
    else if (i_rinse_enable) w_cmd_op = OP_RINSE;
    else if (i_spin_enable)  w_cmd_op = OP_SPIN;
    w_q_full  = (r_count == QCNT_W'(QDEPTH));
    w_head    = r_q[r_rd_ptr];
  end

  // Next-state, timer, queue handshake and fault detection
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_kind_wash_nxt = r_kind_wash;
    w_lock_nxt      = r_door_lock;
    w_done_nxt      = 1'b0;
    w_pop           = 1'b0;
    w_fill_to       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          case (w_head)
            OP_WASH, OP_RINSE: begin
              w_state_nxt     = S_FILL;
              w_kind_wash_nxt = (w_head == OP_WASH);
              w_timer_nxt     = CNT_W'(FILL_TIMEOUT - 1);
              w_lock_nxt      = 1'b1;
            end
            OP_SPIN: begin
              w_state_nxt = S_SPIN;
              w_timer_nxt = CNT_W'(SPIN_CYCLES - 1);
              w_lock_nxt  = 1'b1;
            end
            default: w_lock_nxt = 1'b0;
          endcase
        end
      end
      S_FILL: begin
        if (i_level_full) begin
          w_state_nxt = S_AGITATE;
          w_timer_nxt = r_kind_wash ? CNT_W'(WASH_CYCLES - 1) : CNT_W'(RINSE_CYCLES - 1);
        end else if (r_timer == '0) begin
          w_fill_to = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      S_AGITATE: begin
        if (r_timer == '0) begin
          w_state_nxt = S_DRAIN;
          w_timer_nxt = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      S_DRAIN, S_SPIN: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_FAULT;
    endcase

    // Commands are silently ignored once in FAULT
    w_overflow  = (r_state != S_FAULT) && w_one_cmd && w_q_full && !w_pop;
    w_multi_err = (r_state != S_FAULT) && (w_cmd_sum > 3'd1);
    w_fault_set = w_fill_to || w_overflow || w_multi_err;
    w_push      = (r_state != S_FAULT) && w_one_cmd && (!w_q_full || w_pop) && !w_fault_set;

    if (w_fault_set) begin
      w_state_nxt = S_FAULT;
      w_timer_nxt = '0;
      w_lock_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + QCNT_W'(w_push) - QCNT_W'(w_pop);
    end
  end

  // Queue storage, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (w_push) r_q[r_wr_ptr] <= w_cmd_op;
  end

  // State, timer, queue pointers and Moore-decoded registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_kind_wash   <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_fill_valve  <= 1'b0;
      r_drain_valve <= 1'b0;
      r_heater_on   <= 1'b0;
      r_motor_on    <= 1'b0;
      r_motor_fast  <= 1'b0;
      r_door_lock   <= 1'b0;
      r_busy        <= 1'b0;
      r_phase_done  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_kind_wash <= w_kind_wash_nxt;
      r_count     <= w_count_nxt;
      if (w_fault_set) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_fill_valve  <= (w_state_nxt == S_FILL);
      r_drain_valve <= (w_state_nxt == S_DRAIN) || (w_state_nxt == S_SPIN) || (w_state_nxt == S_FAULT);
      r_heater_on   <= ((w_state_nxt == S_FILL) || (w_state_nxt == S_AGITATE)) && w_kind_wash_nxt;
      r_motor_on    <= (w_state_nxt == S_AGITATE) || (w_state_nxt == S_SPIN);
      r_motor_fast  <= (w_state_nxt == S_SPIN);
      r_door_lock   <= w_lock_nxt;
      r_busy        <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_phase_done  <= w_done_nxt;
      r_fault       <= r_fault || w_fault_set;
    end
  end

  // Sensor readiness flags, one cycle behind the raw inputs in every state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_water_ready <= 1'b0;
      r_temp_ready  <= 1'b0;
      r_load_ready  <= 1'b0;
    end else begin
      r_water_ready <= i_supply_ok;
      r_temp_ready  <= (i_temp_c >= SENS_W'(TEMP_TARGET));
      r_load_ready  <= i_door_closed && (i_load_kg != '0) && (i_load_kg <= SENS_W'(LOAD_MAX));
    end
  end

  assign o_water_ready = r_water_ready;
  assign o_temp_ready  = r_temp_ready;
  assign o_load_ready  = r_load_ready;
  assign o_fill_valve  = r_fill_valve;
  assign o_drain_valve = r_drain_valve;
  assign o_heater_on   = r_heater_on;
  assign o_motor_on    = r_motor_on;
  assign o_motor_fast  = r_motor_fast;
  assign o_door_lock   = r_door_lock;
  assign o_busy        = r_busy;
  assign o_phase_done  = r_phase_done;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_wash_actuator_executor.sv
// Bench for wash_actuator_executor: random command bursts scored against a
// phase-level model, plus directed status, timeout, overflow, multi-pulse and
// reset-abort scenarios.
module tb_wash_actuator_executor;

  localparam int OP_WASH = 0, OP_RINSE = 1, OP_SPIN = 2, OP_DONE = 3;
  localparam int FILL_TO = 16, WASH_N = 32, RINSE_N = 24, DRAIN_N = 8, SPIN_N = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wash_enable = 1'b0, rinse_enable = 1'b0, spin_enable = 1'b0, complete = 1'b0;
  logic supply_ok = 1'b0, door_closed = 1'b0;
  logic level_full = 1'b0;
  logic [7:0] temp_c = 8'd0, load_kg = 8'd0;
  logic water_ready, temp_ready, load_ready, fill_valve, drain_valve, heater_on;
  logic motor_on, motor_fast, door_lock, busy, phase_done, fault;

  always #5 clk = ~clk;

  wash_actuator_executor #(
    .CNT_W(16), .FILL_TIMEOUT(FILL_TO), .WASH_CYCLES(WASH_N), .RINSE_CYCLES(RINSE_N),
    .DRAIN_CYCLES(DRAIN_N), .SPIN_CYCLES(SPIN_N), .TEMP_TARGET(40), .LOAD_MAX(70)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_wash_enable(wash_enable), .i_rinse_enable(rinse_enable),
    .i_spin_enable(spin_enable), .i_complete(complete),
    .i_supply_ok(supply_ok), .i_level_full(level_full), .i_temp_c(temp_c),
    .i_load_kg(load_kg), .i_door_closed(door_closed),
    .o_water_ready(water_ready), .o_temp_ready(temp_ready), .o_load_ready(load_ready),
    .o_fill_valve(fill_valve), .o_drain_valve(drain_valve), .o_heater_on(heater_on),
    .o_motor_on(motor_on), .o_motor_fast(motor_fast), .o_door_lock(door_lock),
    .o_busy(busy), .o_phase_done(phase_done), .o_fault(fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one queued command, as cycle counts per segment
  typedef struct {
    int op; int fill; int agit; int drain; int spin; int heat; bit first;
  } rec_t;

  rec_t sb[$];
  int   dq[$];          // fill delays, in the order FILL phases will occur
  bit   mon_en = 1'b0;
  int   burst_ops[$];
  int   burst_ds[$];

  task automatic expect_cmd(input int op, input int d, input bit first);
    rec_t r;
    r.op    = op;
    r.first = first;
    r.fill  = (op == OP_WASH || op == OP_RINSE) ? d : 0;
    r.agit  = (op == OP_WASH) ? WASH_N : (op == OP_RINSE) ? RINSE_N : 0;
    r.drain = (op == OP_WASH || op == OP_RINSE) ? DRAIN_N : 0;
    r.spin  = (op == OP_SPIN) ? SPIN_N : 0;
    r.heat  = (op == OP_WASH) ? d + WASH_N : 0;
    sb.push_back(r);
    if (op == OP_WASH || op == OP_RINSE) dq.push_back(d);
  endtask

  task automatic set_cmd(input int op);
    wash_enable  = (op == OP_WASH);
    rinse_enable = (op == OP_RINSE);
    spin_enable  = (op == OP_SPIN);
    complete     = (op == OP_DONE);
  endtask

  task automatic clr_cmd();
    wash_enable = 0; rinse_enable = 0; spin_enable = 0; complete = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_timeout"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    clr_cmd();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue the staged burst on consecutive cycles and let it run out
  task automatic run_burst();
    for (int i = 0; i < burst_ops.size(); i++) begin
      expect_cmd(burst_ops[i], burst_ds[i], i == 0);
      set_cmd(burst_ops[i]);
      @(negedge clk);
    end
    clr_cmd();
    wait_idle(2000, "burst");
    @(negedge clk);
    chk("scoreboard_drained", int'(sb.size()), 0);
  endtask

  // Drum level model: raise level_full in the d-th FILL cycle
  bit in_fill = 1'b0;
  int lvl_d = 0, lvl_cnt = 0;
  always @(negedge clk) begin
    if (fill_valve) begin
      if (!in_fill) begin
        in_fill = 1'b1;
        lvl_d   = (dq.size() > 0) ? dq.pop_front() : 1000;
        lvl_cnt = 0;
      end
      lvl_cnt++;
      level_full = (lvl_cnt >= lvl_d);
    end else begin
      in_fill    = 1'b0;
      level_full = 1'b0;
    end
  end

  // Monitor: rebuild each phase from actuator outputs and score on completion
  int   m_fill, m_agit, m_drain, m_spin, m_heat, m_unlock;
  int   idle_run, start_gap, since_done;
  bit   m_active, prev_lock, m_act;
  rec_t m_rec;
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      m_fill = 0; m_agit = 0; m_drain = 0; m_spin = 0; m_heat = 0; m_unlock = 0;
      idle_run = 0; start_gap = 0; since_done = 100; m_active = 0; prev_lock = 0;
    end else begin
      m_act = fill_valve || drain_valve || motor_on;
      since_done++;
      if (m_act) begin
        if (!m_active) begin
          m_active  = 1'b1;
          start_gap = idle_run;
        end
        idle_run = 0;
        if (fill_valve)                  m_fill++;
        else if (motor_on && motor_fast) m_spin++;
        else if (motor_on)               m_agit++;
        else                             m_drain++;
        if (heater_on) m_heat++;
        if (!door_lock) m_unlock++;
      end else begin
        idle_run++;
      end
      if (phase_done) begin
        chk("phase_done_expected", int'(sb.size() > 0), 1);
        chk("phase_done_in_idle", int'(m_act), 0);
        if (sb.size() > 0) begin
          m_rec = sb.pop_front();
          chk("fill_cycles", m_fill, m_rec.fill);
          chk("agitate_cycles", m_agit, m_rec.agit);
          chk("drain_cycles", m_drain, m_rec.drain);
          chk("spin_cycles", m_spin, m_rec.spin);
          chk("heater_cycles", m_heat, m_rec.heat);
          chk("door_unlocked_cycles", m_unlock, 0);
          if (!m_rec.first) chk("idle_gap", start_gap, 1);
        end
        m_fill = 0; m_agit = 0; m_drain = 0; m_spin = 0; m_heat = 0; m_unlock = 0;
        m_active = 0;
        since_done = 0;
      end
      if (prev_lock && !door_lock) begin
        chk("unlock_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          m_rec = sb.pop_front();
          chk("unlock_op", m_rec.op, OP_DONE);
          chk("unlock_delay", since_done, 1);
        end
      end
      prev_lock = door_lock;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({water_ready, temp_ready, load_ready, fill_valve, drain_valve, heater_on,
              motor_on, motor_fast, door_lock, busy, phase_done, fault}), 0);
    reset = 1'b0;

    // Status flags and their thresholds
    supply_ok = 1; temp_c = 8'd40; load_kg = 8'd50; door_closed = 1;
    @(negedge clk);
    chk("water_ready", int'(water_ready), 1);
    chk("temp_ready_40", int'(temp_ready), 1);
    chk("load_ready_50", int'(load_ready), 1);
    temp_c = 8'd39; @(negedge clk); chk("temp_ready_39", int'(temp_ready), 0);
    load_kg = 8'd71; @(negedge clk); chk("load_ready_71", int'(load_ready), 0);
    load_kg = 8'd70; @(negedge clk); chk("load_ready_70", int'(load_ready), 1);
    load_kg = 8'd0;  @(negedge clk); chk("load_ready_0", int'(load_ready), 0);
    load_kg = 8'd50; door_closed = 0; @(negedge clk); chk("load_ready_door", int'(load_ready), 0);
    supply_ok = 0; @(negedge clk); chk("water_ready_off", int'(water_ready), 0);
    supply_ok = 1; door_closed = 1; temp_c = 8'd40;

    // Full cycle, then random bursts through the scoreboard
    mon_en = 1'b1;
    @(negedge clk);
    burst_ops = '{OP_WASH, OP_RINSE, OP_SPIN, OP_DONE};
    burst_ds  = '{3, 3, 0, 0};
    run_burst();
    chk("full_cycle_door_lock", int'(door_lock), 0);
    chk("full_cycle_fault", int'(fault), 0);
    for (int b = 0; b < 12; b++) begin
      burst_ops.delete();
      burst_ds.delete();
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        if (i == n - 1 && n >= 2 && $urandom_range(0, 1) == 1) burst_ops.push_back(OP_DONE);
        else burst_ops.push_back(int'($urandom_range(0, 2)));
        burst_ds.push_back(int'($urandom_range(1, 10)));
      end
      temp_c = 8'($urandom_range(0, 80));
      run_burst();
    end
    chk("random_fault", int'(fault), 0);

    // Reset in the middle of a wash agitate, then a clean wash
    mon_en = 1'b0;
    @(negedge clk);
    dq.delete();
    dq.push_back(3);
    set_cmd(OP_WASH); @(negedge clk); clr_cmd();
    n = 0;
    while (!motor_on && n < 50) begin @(negedge clk); n++; end
    chk("agitate_reached", int'(motor_on), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_actuators", int'({fill_valve, drain_valve, heater_on, motor_on, motor_fast}), 0);
    chk("abort_door_lock", int'(door_lock), 0);
    chk("abort_busy", int'(busy), 0);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    burst_ops = '{OP_WASH};
    burst_ds  = '{3};
    run_burst();
    chk("post_abort_fault", int'(fault), 0);

    // Fill timeout
    mon_en = 1'b0;
    do_reset();
    dq.delete();
    dq.push_back(1000);
    set_cmd(OP_WASH); @(negedge clk); clr_cmd();
    n = 0; cnt = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (fill_valve) cnt++;
      else if (cnt > 0) break;
    end
    chk("fill_timeout_cycles", cnt, FILL_TO);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_drain", int'(drain_valve), 1);
    chk("timeout_fill", int'(fill_valve), 0);
    chk("timeout_heater_motor", int'({heater_on, motor_on}), 0);
    chk("timeout_door_lock", int'(door_lock), 1);
    set_cmd(OP_SPIN); @(negedge clk); clr_cmd();
    cnt = 0;
    repeat (30) begin @(negedge clk); if (motor_on) cnt++; end
    chk("spin_after_fault", cnt, 0);
    chk("fault_sticky", int'(fault), 1);

    // Queue overflow during FILL
    do_reset();
    dq.delete();
    dq.push_back(1000);
    set_cmd(OP_WASH); @(negedge clk); clr_cmd();
    n = 0;
    while (!fill_valve && n < 10) begin @(negedge clk); n++; end
    chk("overflow_fill_entered", int'(fill_valve), 1);
    set_cmd(OP_RINSE); @(negedge clk);
    set_cmd(OP_SPIN);  @(negedge clk);
    set_cmd(OP_RINSE); @(negedge clk);
    set_cmd(OP_SPIN);  @(negedge clk);
    chk("queue_full_no_fault", int'(fault), 0);
    set_cmd(OP_WASH);  @(negedge clk);
    clr_cmd();
    chk("overflow_fault", int'(fault), 1);
    chk("overflow_fill", int'(fill_valve), 0);
    chk("overflow_drain", int'(drain_valve), 1);

    // Two command pulses in the same cycle
    do_reset();
    dq.delete();
    wash_enable = 1; spin_enable = 1;
    @(negedge clk);
    clr_cmd();
    chk("multi_fault", int'(fault), 1);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (fill_valve || motor_on) cnt++; end
    chk("multi_no_phase", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
